lfsr_symbol_modulator: RTL
==========================

Name: lfsr_symbol_modulator

Overview:
- Downstream consumer of the 5-bit LFSR. Takes lfsr[0], which is produced on the divided ~1 Hz LFSR clock, as the symbol stream.
- Synchronises that bit into the 50 MHz system domain and detects symbol changes.
- Applies the symbol to a DDS phase accumulator as ASK, FSK or BPSK modulation.
- Feeds phase_out and amp_en to the sine LUT / waveform output stage.

Parameters:
- ACC_W, 32: phase accumulator and tuning-word width.
- PHASE_W, 12: width of phase_out (top bits of the accumulator).
- SYNC_STAGES, 2: synchroniser depth; legal range 2..4.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- lfsr_bit  in  1  lfsr[0] from the LFSR; asynchronous to clk.
- mod_sel  in  2  modulation select: 00 none, 01 ASK, 10 FSK, 11 BPSK. Sampled every cycle.
- tw_base  in  ACC_W  tuning word for symbol 1, and for all non-FSK modes.
- tw_alt  in  ACC_W  tuning word for symbol 0 in FSK.
- phase_out  out  PHASE_W  registered modulated phase.
- amp_en  out  1  registered amplitude gate.
- sym_bit  out  1  symbol currently applied.
- sym_strobe  out  1  one-cycle pulse in the cycle sym_bit changes.

Behaviour:
- Reset (async assert, sync release):
  - synchroniser flops preset to 1, matching the LFSR seed 11111;
  - sym_bit=1, acc=0, phase_out=0, amp_en=1, sym_strobe=0, state=TRACK.
- Synchroniser: SYNC_STAGES flop chain; sync_out is the last stage.
- Accumulator: acc <= acc + tw_sel every cycle, modulo 2^ACC_W.
  - tw_sel = tw_alt when mod_sel=FSK and sym_bit=0; tw_base otherwise.
  - wrap = carry out of that addition.
- Phase output: phase_out <= acc[ACC_W-1 -: PHASE_W] + offset, modulo 2^PHASE_W.
  - offset = 2^(PHASE_W-1) when mod_sel=BPSK and sym_bit=0; 0 otherwise.
  - Uses the pre-update acc, i.e. one cycle of output latency.
- Amplitude gate: amp_en <= 0 only when mod_sel=ASK and sym_bit=0; 1 otherwise.
- Symbol update, default build:
  - When sync_out != sym_bit: sym_bit <= sync_out and sym_strobe <= 1 on the same edge.
  - Latency: sym_bit changes on edge SYNC_STAGES+1, counting the first edge that samples the new lfsr_bit as edge 1.
- mod_sel=none: sym_bit and sym_strobe still track the input; phase and amplitude are unaffected.
- mod_sel change mid-symbol: takes effect on the next edge, with no accumulator reset.
- Reset asserted mid-operation: returns everything to reset values immediately; no strobe is generated on release.
- An lfsr_bit glitch shorter than one clk period may be missed. It must never produce two strobes per real transition.

Optional Feature:
- Macro: LFSR_MOD_PHASE_ALIGN_EN.
- Enabled: phase-continuous switching via a 2-state FSM.
  - TRACK: sync_out != sym_bit -> go to PENDING, no update yet.
  - PENDING, sync_out == sym_bit again: cancel, return to TRACK, no strobe.
  - PENDING, wrap=1 or tw_sel=0: apply the update and strobe on that edge, return to TRACK. The tw_sel=0 condition prevents deadlock.
  - PENDING otherwise: stay.
- Disabled: no FSM; update as in the default build.

Decomposition:
- Package lab5_mod_pkg:
  - mod_sel_t enum: MOD_NONE=0, MOD_ASK=1, MOD_FSK=2, MOD_BPSK=3;
  - align_state_t enum: TRACK, PENDING;
  - constant SYNC_RESET_VAL=1'b1.
- Sub-module bit_sync: parameterised SYNC_STAGES chain with async active-low preset. Reusable for other slow-clock-domain signals.

Test Plan:
- Reset, lfsr_bit=1, mod_sel=00, tw_base=32'h0100_0000:
  - sym_bit=1, amp_en=1, no strobe;
  - phase_out increments by 16 every cycle after the 1-cycle latency.
- lfsr_bit 1->0, SYNC_STAGES=2, default build:
  - sym_strobe high exactly on edge 3, for exactly 1 cycle;
  - sym_bit=0 from edge 3.
- mod_sel=ASK, symbol 0: amp_en=0 the cycle after sym_bit falls; symbol back to 1 -> amp_en=1.
- mod_sel=FSK, tw_base=32'h0100_0000, tw_alt=32'h0200_0000, symbol 0: phase_out step changes from 16 to 32 per cycle.
- mod_sel=BPSK, PHASE_W=12: symbol change 1->0 adds 12'h800 to phase_out relative to the unmodulated accumulator.
- LFSR_MOD_PHASE_ALIGN_EN defined, tw_base=32'h4000_0000:
  - strobe only on a cycle where acc wraps;
  - an input pulse reverted before the wrap gives no strobe;
  - tw_base=0 gives a strobe on the first PENDING cycle;
  - reset asserted in PENDING -> TRACK, sym_bit=1.

Source files
------------

// File: rtl/lab5_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab5_mod_pkg
//  Description : Shared types and constants for the LFSR symbol modulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package lab5_mod_pkg;

    typedef enum logic [1:0] {
        MOD_NONE = 2'd0,
        MOD_ASK  = 2'd1,
        MOD_FSK  = 2'd2,
        MOD_BPSK = 2'd3
    } mod_sel_t;

    typedef enum logic [0:0] {
        TRACK   = 1'b0,
        PENDING = 1'b1
    } align_state_t;

    // Matches the LFSR seed 11111 so release from reset is strobe-free
    localparam logic SYNC_RESET_VAL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bit_sync
//  Description : Multi-flop synchroniser with asynchronous active-low preset,
//                for single slow-domain control bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/lfsr_symbol_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_symbol_modulator
//  Description : Synchronises lfsr[0] as a symbol stream and applies it to a
//                DDS phase accumulator as ASK, FSK or BPSK.
//                Define LFSR_MOD_PHASE_ALIGN_EN for phase-continuous switching
//                (symbol updates held until the accumulator wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_symbol_modulator #(
    parameter int ACC_W       = 32,
    parameter int PHASE_W     = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lfsr_bit,
    input  logic [1:0]         mod_sel,
    input  logic [ACC_W-1:0]   tw_base,
    input  logic [ACC_W-1:0]   tw_alt,
    output logic [PHASE_W-1:0] phase_out,
    output logic               amp_en,
    output logic               sym_bit,
    output logic               sym_strobe
);

    import lab5_mod_pkg::*;

    logic               w_sync_out;
    mod_sel_t           w_mod;
    logic [ACC_W-1:0]   w_tw_sel;
    logic [ACC_W-1:0]   w_acc_next;
    logic [PHASE_W-1:0] w_offset;
    logic               w_amp_next;
    logic               w_update;

    logic [ACC_W-1:0]   r_acc;
    logic [PHASE_W-1:0] r_phase;
    logic               r_amp_en;
    logic               r_sym_bit;
    logic               r_sym_strobe;

    bit_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (SYNC_RESET_VAL)
    ) u_bit_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (lfsr_bit),
        .q     (w_sync_out)
    );

    assign w_mod = mod_sel_t'(mod_sel);

`ifdef LFSR_MOD_PHASE_ALIGN_EN
    logic         w_wrap;
    align_state_t r_state;
    align_state_t w_state_next;

    always_comb begin
        w_tw_sel = (w_mod == MOD_FSK && !r_sym_bit) ? tw_alt : tw_base;
        {w_wrap, w_acc_next} = {1'b0, r_acc} + {1'b0, w_tw_sel};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= TRACK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A zero tuning word never wraps, so it releases the update immediately
    always_comb begin
        w_state_next = r_state;
        w_update     = 1'b0;
        case (r_state)
            TRACK: begin
                if (w_sync_out != r_sym_bit) begin
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                if (w_sync_out == r_sym_bit) begin
                    w_state_next = TRACK;
                end else if (w_wrap || (w_tw_sel == '0)) begin
                    w_update     = 1'b1;
                    w_state_next = TRACK;
                end
            end
            default: w_state_next = TRACK;
        endcase
    end
`else
    always_comb begin
        w_tw_sel   = (w_mod == MOD_FSK && !r_sym_bit) ? tw_alt : tw_base;
        w_acc_next = r_acc + w_tw_sel;
    end

    assign w_update = (w_sync_out != r_sym_bit);
`endif

    always_comb begin
        w_offset   = '0;
        w_amp_next = 1'b1;
        if (w_mod == MOD_BPSK && !r_sym_bit) begin
            w_offset = {1'b1, {(PHASE_W-1){1'b0}}};
        end
        if (w_mod == MOD_ASK && !r_sym_bit) begin
            w_amp_next = 1'b0;
        end
    end

    // Phase is taken from the pre-update accumulator: one cycle of latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc        <= '0;
            r_phase      <= '0;
            r_amp_en     <= 1'b1;
            r_sym_bit    <= 1'b1;
            r_sym_strobe <= 1'b0;
        end else begin
            r_acc        <= w_acc_next;
            r_phase      <= r_acc[ACC_W-1 -: PHASE_W] + w_offset;
            r_amp_en     <= w_amp_next;
            r_sym_strobe <= w_update;
            if (w_update) begin
                r_sym_bit <= w_sync_out;
            end
        end
    end

    assign phase_out  = r_phase;
    assign amp_en     = r_amp_en;
    assign sym_bit    = r_sym_bit;
    assign sym_strobe = r_sym_strobe;

endmodule
`default_nettype wire
